fp16_packer: RTL
================

FP16_PACKER -- requirements
Module: fp16_packer

Interface
REQ-001 SHALL have parameter PACK, default 4, giving FP16 lanes per output word; legal values are 2 and 4.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream element valid.
REQ-005 SHALL have port in_ready  output  1  element accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data  input  32  IEEE FP32 element.
REQ-007 SHALL have port in_last  input  1  element closes the current group.
REQ-008 SHALL have port out_valid  output  1  packed word valid.
REQ-009 SHALL have port out_ready  input  1  word consumed when out_valid && out_ready.
REQ-010 SHALL have port out_data  output  16*PACK  packed FP16 lanes, lane 0 in bits [15:0].
REQ-011 SHALL have port out_mask  output  PACK  bit i set when lane i holds data.
REQ-012 SHALL have port out_last  output  1  in_last of the group's closing element.
REQ-013 SHALL have port ovf_cnt  output  16  count of accepted elements that overflowed.

Function
REQ-014 SHALL convert each accepted element: sign copied; FP32 exponent >142 -> exp 11111, frac 0; exponent <113 -> exp 00000, frac 0 (signed zero); otherwise exp = exp32-112, frac = in_data[22:13] (truncation, no rounding).
REQ-015 SHALL treat FP32 Inf/NaN (exponent 255) as overflow per REQ-014.
REQ-016 SHALL write the k-th accepted element of a group (k = 0..PACK-1) into lane k of an accumulation register and set its mask bit.
REQ-017 SHALL close a group when an element is accepted into lane PACK-1 or carries in_last=1, whichever comes first.
REQ-018 SHALL drive unfilled lanes of a closed group as 16'h0000 with mask bit 0.
REQ-019 SHALL load a closed group into the output register on the accepting edge; out_valid rises the following cycle (latency 1 from closing acceptance).
REQ-020 SHALL drive in_ready = !out_valid || out_ready, combinationally, in every state.
REQ-021 SHALL, when a word is consumed and a new group closes on the same edge, reload the output register with out_valid held high (no bubble).
REQ-022 SHALL hold out_data, out_mask, out_last stable while out_valid && !out_ready.
REQ-023 SHALL reset the lane index to 0 after every group close.
REQ-024 SHALL increment ovf_cnt by 1 per accepted overflowing element, saturating at 16'hFFFF.
REQ-025 SHALL not produce an output word for an empty group; in_last is meaningful only with an accepted element.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, set out_valid=0, out_data=0, out_mask=0, out_last=0, ovf_cnt=0, lane index=0, and clear the accumulation register.
REQ-027 SHALL discard a partially filled group and any pending output word on reset mid-operation.
REQ-028 SHALL hold in_ready=1 during and after reset (out_valid=0).

Configuration
REQ-029 SHALL support macro FP16_PACK_SAT_EN: when defined, overflowing elements convert to max finite magnitude (exp 11110, frac 1111111111, sign kept); when undefined, they convert to Inf per REQ-014.
REQ-030 SHALL increment ovf_cnt on overflow identically with or without FP16_PACK_SAT_EN.

Verification
REQ-031 SHALL cover: PACK=4, inputs 0x3F800000, 0x40000000, 0xBFC00000, 0x3F000000, out_ready=1 -> out_data=0x3800_BE00_4000_3C00, out_mask=4'b1111, out_last=0, one cycle after 4th accept.
REQ-032 SHALL cover: input 0x47800000 then 0x3F800000 with in_last=1 -> lanes 0x7C00 (0x7BFF with FP16_PACK_SAT_EN), 0x3C00; mask 4'b0011; out_last=1; ovf_cnt=1.
REQ-033 SHALL cover: input 0xB3800000 with in_last=1 -> out_data lane 0 = 0x8000, mask 4'b0001, ovf_cnt unchanged.
REQ-034 SHALL cover: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, outputs stable; out_ready=1 with closing element present -> back-to-back words, out_valid never drops.
REQ-035 SHALL cover: 2 elements accepted, rst=1 for one cycle, then 4 new elements -> only one word, containing the 4 new elements, mask 4'b1111.
REQ-036 SHALL cover: 65540 overflowing elements -> ovf_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/fp16_packer.sv
// fp16_packer: converts FP32 elements to FP16 and packs PACK lanes per word.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_data/in_last,
//        out_valid/out_ready/out_data/out_mask/out_last, ovf_cnt.
// Option: define FP16_PACK_SAT_EN to clamp overflow to max finite, not Inf.
module fp16_packer #(
    parameter int PACK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*PACK-1:0]   out_data,
    output logic [PACK-1:0]      out_mask,
    output logic                 out_last,
    output logic [15:0]          ovf_cnt
);

    localparam int W = 16 * PACK;
    localparam logic [1:0] LAST_LANE = 2'(PACK - 1);

    logic [W-1:0]    acc_q, acc_d;
    logic [PACK-1:0] acc_mask_q, acc_mask_d;
    logic [1:0]      lane_q, lane_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [PACK-1:0] out_mask_q, out_mask_d;
    logic            out_last_q, out_last_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     ovf_q, ovf_d;

    logic [7:0]      exp32;
    logic            is_ovf;
    logic            is_unf;
    logic [15:0]     half;
    logic            accept;
    logic            close;
    logic [W-1:0]    acc_new;
    logic [PACK-1:0] mask_new;
    logic            unused_bits;

    assign unused_bits = ^in_data[12:0];

    // FP32 -> FP16 with truncation; exp32-112 equals exp32[4:0]-16 mod 32
    always_comb begin
        exp32  = in_data[30:23];
        is_ovf = exp32 > 8'd142;
        is_unf = exp32 < 8'd113;
        half   = {in_data[31], in_data[27:23] - 5'd16, in_data[22:13]};
        if (is_ovf) begin
`ifdef FP16_PACK_SAT_EN
            half = {in_data[31], 5'b11110, 10'h3FF};
`else
            half = {in_data[31], 5'b11111, 10'h000};
`endif
        end else if (is_unf) begin
            half = {in_data[31], 15'h0000};
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign close    = accept && ((lane_q == LAST_LANE) || in_last);

    always_comb begin
        acc_new  = acc_q;
        mask_new = acc_mask_q;
        for (int i = 0; i < PACK; i++) begin
            if (lane_q == 2'(i)) begin
                acc_new[i*16 +: 16] = half;
                mask_new[i]         = 1'b1;
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        acc_mask_d  = acc_mask_q;
        lane_d      = lane_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (is_ovf && (ovf_q != 16'hFFFF)) begin
                ovf_d = ovf_q + 16'd1;
            end
            if (close) begin
                // Output slot is free here because accept implies in_ready
                out_data_d  = acc_new;
                out_mask_d  = mask_new;
                out_last_d  = in_last;
                out_valid_d = 1'b1;
                acc_d       = '0;
                acc_mask_d  = '0;
                lane_d      = 2'd0;
            end else begin
                acc_d      = acc_new;
                acc_mask_d = mask_new;
                lane_d     = lane_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            acc_mask_q  <= '0;
            lane_q      <= 2'd0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 16'd0;
        end else begin
            acc_q       <= acc_d;
            acc_mask_q  <= acc_mask_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mask  = out_mask_q;
    assign out_last  = out_last_q;
    assign ovf_cnt   = ovf_q;

endmodule
